// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and the write-back bundle for the MEM/WB pipeline register.
// Used by mem_wb_stage and wb_perf_counters.
package mem_wb_stage_pkg;

  localparam int ADDRESS_LEN       = 32;
  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 4;
  localparam int PERF_CNT_W        = 32;

  typedef struct packed {
    logic                         valid;
    logic                         wb_en;
    logic [REG_FILE_ADDR_LEN-1:0] dest;
    logic [WORD_LEN-1:0]          value;
    logic [ADDRESS_LEN-1:0]       pc;
  } wb_bundle_t;

  // Load data wins over the ALU result for loads.
  function automatic logic [WORD_LEN-1:0] wb_select(
    input logic                is_load,
    input logic [WORD_LEN-1:0] mem_data,
    input logic [WORD_LEN-1:0] alu_res
  );
    return is_load ? mem_data : alu_res;
  endfunction

endpackage

// File: rtl/wb_perf_counters.sv
// Retire / load / stall performance counters for the write-back stage.
// Wrap modulo 2^32; a synchronous clear overrides same-cycle increments.
module wb_perf_counters
  import mem_wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_i,
  input  logic                  load_i,
  input  logic                  stall_i,
  input  logic                  clr_i,
  output logic [PERF_CNT_W-1:0] retire_cnt_o,
  output logic [PERF_CNT_W-1:0] load_cnt_o,
  output logic [PERF_CNT_W-1:0] stall_cnt_o
);

  logic [PERF_CNT_W-1:0] retire_q, retire_d;
  logic [PERF_CNT_W-1:0] load_q,   load_d;
  logic [PERF_CNT_W-1:0] stall_q,  stall_d;

  always_comb begin
    retire_d = retire_q + PERF_CNT_W'(cap_i);
    load_d   = load_q   + PERF_CNT_W'(cap_i & load_i);
    stall_d  = stall_q  + PERF_CNT_W'(stall_i);
    if (clr_i) begin
      retire_d = '0;
      load_d   = '0;
      stall_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      load_q   <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_d;
      load_q   <= load_d;
      stall_q  <= stall_d;
    end
  end

  assign retire_cnt_o = retire_q;
  assign load_cnt_o   = load_q;
  assign stall_cnt_o  = stall_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with registered load/ALU write-back selection.
// Optional performance counters are built when WB_PERF_CNT_EN is defined.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W     = ADDRESS_LEN,
  parameter int DATA_W     = WORD_LEN,
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic                  cnt_clr,
  output logic [ADDR_W-1:0]     pc,
  output logic                  wb_valid,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0]     wb_value,
  output logic [31:0]           retire_cnt,
  output logic [31:0]           load_cnt,
  output logic [31:0]           stall_cnt
);

  // The bundle type is sized by the package, so overrides must agree with it.
  if (ADDR_W != ADDRESS_LEN || DATA_W != WORD_LEN || REG_ADDR_W != REG_FILE_ADDR_LEN)
  begin : g_width_mismatch
    $error("mem_wb_stage: parameter widths must match mem_wb_stage_pkg");
  end

  logic       cap;
  wb_bundle_t wb_q, wb_d;

  assign cap = mem_ready & mem_valid;

  // NOTE: every field gets a default before the branch, so no latch is inferred.
  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    wb_d.wb_en = 1'b0;
    if (cap) begin
      wb_d.valid = 1'b1;
      wb_d.wb_en = wb_en_in;
      wb_d.dest  = dest_in;
      wb_d.value = wb_select(mem_r_en_in, mem_data_in, alu_res_in);
      wb_d.pc    = pc_in;
    end
  end

  // NOTE: non-blocking assignment keeps register updates order-independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign pc       = wb_q.pc;
  assign wb_valid = wb_q.valid;
  assign wb_en    = wb_q.wb_en;
  assign wb_dest  = wb_q.dest;
  assign wb_value = wb_q.value;

`ifdef WB_PERF_CNT_EN
  wb_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst),
    .cap_i        (cap),
    .load_i       (mem_r_en_in),
    .stall_i      (~mem_ready),
    .clr_i        (cnt_clr),
    .retire_cnt_o (retire_cnt),
    .load_cnt_o   (load_cnt),
    .stall_cnt_o  (stall_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign retire_cnt     = '0;
  assign load_cnt       = '0;
  assign stall_cnt      = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, scoreboard queue and
// hand-written stall / reset / counter sequences.
`timescale 1ns/1ps
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

`ifdef WB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready, mem_valid, wb_en_in, mem_r_en_in, cnt_clr;
  logic [31:0] pc_in, alu_res_in, mem_data_in;
  logic [3:0]  dest_in;
  logic [31:0] pc, wb_value, retire_cnt, load_cnt, stall_cnt;
  logic        wb_valid, wb_en;
  logic [3:0]  wb_dest;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .mem_data_in(mem_data_in),
    .cnt_clr(cnt_clr), .pc(pc), .wb_valid(wb_valid), .wb_en(wb_en),
    .wb_dest(wb_dest), .wb_value(wb_value), .retire_cnt(retire_cnt),
    .load_cnt(load_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ready, valid, wb_en_in, rd, clr;
    logic [3:0]  dest;
    logic [31:0] alu, data, pc_in;
    logic        e_valid, e_en, e_cmp;
    logic [3:0]  e_dest;
    logic [31:0] e_value, e_pc;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] retire, load, stall;
  } exp_t;

  exp_t        sb[$];
  vec_t        table_v[6];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_retire = '0, m_load = '0, m_stall = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string name, input logic ready, input logic valid, input logic wen,
    input logic rd, input logic clr, input logic [3:0] dest, input logic [31:0] alu,
    input logic [31:0] data, input logic [31:0] pcv, input logic e_valid,
    input logic e_en, input logic e_cmp, input logic [3:0] e_dest,
    input logic [31:0] e_value, input logic [31:0] e_pc
  );
    vec_t v;
    v.name = name; v.ready = ready; v.valid = valid; v.wb_en_in = wen; v.rd = rd;
    v.clr = clr; v.dest = dest; v.alu = alu; v.data = data; v.pc_in = pcv;
    v.e_valid = e_valid; v.e_en = e_en; v.e_cmp = e_cmp; v.e_dest = e_dest;
    v.e_value = e_value; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic drive_idle();
    mem_ready = 1'b1; mem_valid = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0;
    cnt_clr = 1'b0; dest_in = '0; alu_res_in = '0; mem_data_in = '0; pc_in = '0;
  endtask

  task automatic compare(input exp_t e);
    check({e.v.name, ".wb_valid"}, 32'(wb_valid), 32'(e.v.e_valid));
    check({e.v.name, ".wb_en"},    32'(wb_en),    32'(e.v.e_en));
    if (e.v.e_cmp) begin
      check({e.v.name, ".wb_dest"},  32'(wb_dest), 32'(e.v.e_dest));
      check({e.v.name, ".wb_value"}, wb_value,     e.v.e_value);
      check({e.v.name, ".pc"},       pc,           e.v.e_pc);
    end
    check({e.v.name, ".retire_cnt"}, retire_cnt, e.retire);
    check({e.v.name, ".load_cnt"},   load_cnt,   e.load);
    check({e.v.name, ".stall_cnt"},  stall_cnt,  e.stall);
  endtask

  // Drive one vector on the falling edge, predict, then compare after the rising edge.
  task automatic step(input vec_t v);
    exp_t e;
    logic cap;
    @(negedge clk);
    mem_ready = v.ready; mem_valid = v.valid; wb_en_in = v.wb_en_in;
    mem_r_en_in = v.rd; cnt_clr = v.clr; dest_in = v.dest;
    alu_res_in = v.alu; mem_data_in = v.data; pc_in = v.pc_in;
    cap = v.ready & v.valid;
    if (v.clr) begin
      m_retire = '0; m_load = '0; m_stall = '0;
    end else begin
      if (cap)          m_retire = m_retire + 32'd1;
      if (cap && v.rd)  m_load   = m_load + 32'd1;
      if (!v.ready)     m_stall  = m_stall + 32'd1;
    end
    e.v      = v;
    e.retire = PERF ? m_retire : 32'd0;
    e.load   = PERF ? m_load   : 32'd0;
    e.stall  = PERF ? m_stall  : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      compare(sb.pop_front());
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".pc"},         pc,              32'd0);
    check({name, ".wb_valid"},   32'(wb_valid),   32'd0);
    check({name, ".wb_en"},      32'(wb_en),      32'd0);
    check({name, ".wb_dest"},    32'(wb_dest),    32'd0);
    check({name, ".wb_value"},   wb_value,        32'd0);
    check({name, ".retire_cnt"}, retire_cnt,      32'd0);
    check({name, ".load_cnt"},   load_cnt,        32'd0);
    check({name, ".stall_cnt"},  stall_cnt,       32'd0);
  endtask

  initial begin
    //                 name        rdy vld wen rd clr dest  alu           data          pc            ev en cmp edst  evalue        epc
    table_v[0] = mk("alu_wb",     1, 1, 1, 0, 0, 4'd3,  32'h0000_1234, 32'h0000_DEAD, 32'h0000_0014, 1, 1, 1, 4'd3,  32'h0000_1234, 32'h0000_0014);
    table_v[1] = mk("load_wb",    1, 1, 1, 1, 0, 4'd7,  32'h0000_0100, 32'hBEEF_0001, 32'h0000_0018, 1, 1, 1, 4'd7,  32'hBEEF_0001, 32'h0000_0018);
    table_v[2] = mk("bubble",     1, 0, 1, 0, 0, 4'd9,  32'h5555_5555, 32'h6666_6666, 32'h0000_001C, 0, 0, 0, 4'd0,  32'h0,         32'h0);
    table_v[3] = mk("store_nowb", 1, 1, 0, 0, 0, 4'd2,  32'h0000_2000, 32'h0000_0BAD, 32'h0000_0020, 1, 0, 1, 4'd2,  32'h0000_2000, 32'h0000_0020);
    table_v[4] = mk("alu_max",    1, 1, 1, 0, 0, 4'd15, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFC, 1, 1, 1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    table_v[5] = mk("load_b2b",   1, 1, 1, 1, 0, 4'd1,  32'h0000_0004, 32'h0123_4567, 32'h0000_0024, 1, 1, 1, 4'd1,  32'h0123_4567, 32'h0000_0024);

    rst = 1'b0;
    drive_idle();
    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) step(table_v[i]);

    // Clear with a simultaneous capture leaves every counter at zero.
    step(mk("clr_cap", 1, 1, 1, 1, 1, 4'd4, 32'h0000_0040, 32'h0000_AAAA, 32'h0000_0028, 1, 1, 1, 4'd4, 32'h0000_AAAA, 32'h0000_0028));

    // Stalled load: stale data during the stall must never reach the register file.
    for (int i = 0; i < 4; i++)
      step(mk("stall", 0, 1, 1, 1, 0, 4'd5, 32'h0000_0500, 32'h1111_0000 + 32'(i), 32'h0000_002C, 0, 0, 0, 4'd0, 32'h0, 32'h0));
    step(mk("stall_done", 1, 1, 1, 1, 0, 4'd5, 32'h0000_0500, 32'hCAFE_F00D, 32'h0000_002C, 1, 1, 1, 4'd5, 32'hCAFE_F00D, 32'h0000_002C));
    check("stall_total", stall_cnt, PERF ? 32'd4 : 32'd0);
    check("load_total",  load_cnt,  PERF ? 32'd1 : 32'd0);
    step(mk("after_stall", 1, 0, 1, 0, 0, 4'd5, 32'h0, 32'h0, 32'h0, 0, 0, 0, 4'd0, 32'h0, 32'h0));

`ifdef WB_PERF_CNT_EN
    // Retire counter wraps from all-ones to zero on a capture.
    @(negedge clk);
    drive_idle();
    force dut.u_perf.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf.retire_q;
    m_retire = 32'hFFFF_FFFF;
    check("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
    step(mk("wrap_cap", 1, 1, 0, 0, 0, 4'd6, 32'h0000_0060, 32'h0, 32'h0000_0030, 1, 0, 1, 4'd6, 32'h0000_0060, 32'h0000_0030));
`endif

    // Asynchronous reset in the middle of capture traffic.
    step(mk("pre_rst_a", 1, 1, 1, 0, 0, 4'd8, 32'h0000_0080, 32'h0, 32'h0000_0034, 1, 1, 1, 4'd8, 32'h0000_0080, 32'h0000_0034));
    step(mk("pre_rst_b", 1, 1, 1, 1, 0, 4'd9, 32'h0, 32'h0000_0099, 32'h0000_0038, 1, 1, 1, 4'd9, 32'h0000_0099, 32'h0000_0038));
    @(negedge clk);
    mem_ready = 1'b1; mem_valid = 1'b1; wb_en_in = 1'b1; dest_in = 4'd10;
    alu_res_in = 32'h0000_00AA; pc_in = 32'h0000_003C;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_async");
    m_retire = '0; m_load = '0; m_stall = '0;
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    step(mk("first_after_rst", 1, 1, 1, 0, 0, 4'd11, 32'h0000_0BBB, 32'h0000_0CCC, 32'h0000_0010, 1, 1, 1, 4'd11, 32'h0000_0BBB, 32'h0000_0010));

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

- Pipeline register and write-back selector between the memory stage and the register file.
- Captures the memory stage's results only when the memory subsystem (SRAM or cache) reports ready, so each instruction is written back exactly once.
- Selects loaded data or the ALU result as the write-back value.
- Exposes the write-back destination and value for forwarding into the execute stage.

## Interface
Parameters:
- ADDR_W, 32, PC/address width
- DATA_W, 32, data word width
- REG_ADDR_W, 4, register-file index width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- mem_ready  in  1  memory subsystem ready; 0 = current memory access still in progress
- mem_valid  in  1  memory stage holds a real instruction (0 = bubble)
- pc_in  in  ADDR_W  PC of the memory-stage instruction
- wb_en_in  in  1  instruction writes a register
- mem_r_en_in  in  1  instruction is a load
- dest_in  in  REG_ADDR_W  destination register
- alu_res_in  in  DATA_W  ALU result / effective address
- mem_data_in  in  DATA_W  load data from memory stage; meaningful only while mem_ready=1
- cnt_clr  in  1  synchronous clear of performance counters (ignored unless counters are compiled in)
- pc  out  ADDR_W  registered PC of the write-back instruction
- wb_valid  out  1  write-back slot holds a real instruction this cycle
- wb_en  out  1  register-file write enable
- wb_dest  out  REG_ADDR_W  register-file write index
- wb_value  out  DATA_W  register-file write data
- retire_cnt  out  32  retired instructions (only with WB_PERF_CNT_EN)
- load_cnt  out  32  retired loads (only with WB_PERF_CNT_EN)
- stall_cnt  out  32  cycles with mem_ready=0 (only with WB_PERF_CNT_EN)

## Operation
- Capture condition: `cap = mem_ready & mem_valid`.
- On cap, register:
  - pc ← pc_in
  - wb_valid ← 1
  - wb_en ← wb_en_in
  - wb_dest ← dest_in
  - is_load ← mem_r_en_in
  - data ← mem_r_en_in ? mem_data_in : alu_res_in
- When cap=0, insert a bubble:
  - wb_valid ← 0 and wb_en ← 0.
  - pc, wb_dest and wb_value keep their last values (don't-care).
- The load/ALU selection is registered, never combinational, so no SRAM-to-register-file combinational path exists.
- wb_en is never 1 while wb_valid is 0.
- A stalled instruction (mem_ready=0 for N cycles) produces N bubbles, then exactly one write-back in the cycle after mem_ready rises.
- Forwarding uses wb_en/wb_dest/wb_value directly; no extra port is needed.

## Timing
- Latency: 1 cycle from a cap edge to the outputs.
- Throughput: 1 instruction/cycle while mem_ready=1.
- Reset (rst=0, asynchronous):
  - pc, wb_value, wb_dest, wb_valid, wb_en and all counters become 0 immediately.
  - This holds even mid-stall or mid-capture.
- First capture is on the first rising edge with rst=1 and cap=1.
- mem_ready=1 with mem_valid=0: bubble, no counter increment except as stated below.
- A load whose data arrives in the same cycle mem_ready rises is captured on that edge.
- The mem_data_in value from earlier stalled cycles is never used.

## Configuration
- Macro: `WB_PERF_CNT_EN`.
- Defined: three 32-bit counters, all wrap-around modulo 2^32:
  - retire_cnt: +1 per cap
  - load_cnt: +1 per cap with mem_r_en_in=1
  - stall_cnt: +1 per cycle with mem_ready=0, independent of mem_valid
- cnt_clr=1 zeroes all three on the next edge. Clear beats a simultaneous increment, so the result is 0, not 1.
- Undefined: no counter flops; retire_cnt, load_cnt and stall_cnt are tied to 0; cnt_clr is ignored.

## Structure
- Shared package (alongside configs.v): ADDRESS_LEN, WORD_LEN, REG_FILE_ADDR_LEN, and a wb_bundle_t typedef (valid, wb_en, dest, value, pc).
- One sub-module, `wb_perf_counters`: holds the three counters and the clear logic.
  - Instantiated only under WB_PERF_CNT_EN.
- The pipeline register and selector live in mem_wb_stage itself.

## Test plan
- Reset mid-stream: drive cap=1 traffic, pull rst=0 between edges → all outputs 0 without a clock edge. After release, first cap with pc_in=0x10 gives pc=0x10 one cycle later.
- ALU write-back: cap with wb_en_in=1, mem_r_en_in=0, dest_in=3, alu_res_in=0x1234, mem_data_in=0xDEAD → next cycle wb_en=1, wb_dest=3, wb_value=0x1234.
- Stalled load: mem_valid=1, mem_r_en_in=1, dest_in=5, mem_ready=0 for 4 cycles, then mem_ready=1 with mem_data_in=0xCAFEF00D →
  - 4 bubbles (wb_en=0)
  - then one cycle with wb_en=1, wb_value=0xCAFEF00D
  - with counters: stall_cnt=4, load_cnt=1
- Bubble: mem_ready=1, mem_valid=0, wb_en_in=1 → wb_valid=0, wb_en=0, retire_cnt unchanged.
- Counter wrap/clear (WB_PERF_CNT_EN):
  - Force retire_cnt=0xFFFFFFFF, one cap → 0.
  - cnt_clr=1 in the same cycle as a cap → all counters 0.
  - Macro undefined → counters read 0 throughout.
